// File: rtl/qr_mac_sequencer_if.sv
// qr_mac_sequencer_if
//   Request/result handshake bundle between the layer/tile controller (master) and the
//   bit-serial MAC sequencer (slave).
//   Signals:
//     n_input_bits_cfg, binary_cfg : request config, sampled at the accept handshake
//     in_valid_i / in_ready_o      : input vector handshake
//     in_data_i                    : per-row input word
//     acc_valid_o / acc_ready_i    : result handshake
//     acc_data_o                   : signed per-column result
//   The _i/_o suffixes are from the sequencer's point of view.
interface qr_mac_sequencer_if #(
   parameter int unsigned numRows    = 128,
   parameter int unsigned numCols    = 8,
   parameter int unsigned numInBits  = 8,
   parameter int unsigned numAccBits = 12,
   parameter int unsigned numCfgBits = 8
);
   logic [numCfgBits-1:0]                 n_input_bits_cfg;
   logic                                  binary_cfg;
   logic                                  in_valid_i;
   logic                                  in_ready_o;
   logic [numRows-1:0][numInBits-1:0]     in_data_i;
   logic                                  acc_valid_o;
   logic                                  acc_ready_i;
   logic [numCols-1:0][numAccBits-1:0]    acc_data_o;

   modport slave (
      input  n_input_bits_cfg, binary_cfg, in_valid_i, in_data_i, acc_ready_i,
      output in_ready_o, acc_valid_o, acc_data_o
   );

   modport master (
      output n_input_bits_cfg, binary_cfg, in_valid_i, in_data_i, acc_ready_i,
      input  in_ready_o, acc_valid_o, acc_data_o
   );
endinterface

// File: rtl/qr_mac_sequencer.sv
// qr_mac_sequencer
//   Bit-serial MAC sequencer. Accepts one input vector per request, presents it to the
//   array one bit-plane per cycle (LSB first) on data_p_o/data_n_o, and shift-adds the
//   returning per-column ADC partial sums into a signed per-column dot product.
//   Ports:
//     clk, rst     : clock, synchronous active-high reset
//     bus          : request/result handshake (qr_mac_sequencer_if.slave)
//     mac_en_o     : wrapper MAC enable, high while bit-planes are issued
//     data_p_o/n_o : per-row bit-plane drive
//     adc_out_i    : signed encoded per-column ADC partial sums, adcLatency cycles behind
//   Build option:
//     QR_SEQ_SATURATE_EN : saturating accumulation with a sticky per-column overflow flag;
//                          otherwise accumulation wraps modulo 2^numAccBits.
module qr_mac_sequencer #(
   parameter int unsigned numRows    = 128,
   parameter int unsigned numCols    = 8,
   parameter int unsigned numAdcBits = 4,
   parameter int unsigned numInBits  = 8,
   parameter int unsigned numAccBits = 12,
   parameter int unsigned numCfgBits = 8,
   parameter int unsigned adcLatency = 2
) (
   input  logic                                 clk,
   input  logic                                 rst,
   qr_mac_sequencer_if.slave                    bus,
   output logic                                 mac_en_o,
   output logic [numRows-1:0]                   data_p_o,
   output logic [numRows-1:0]                   data_n_o,
   input  logic [numCols-1:0][numAdcBits-1:0]   adc_out_i
);

   localparam int unsigned CntW  = $clog2(numInBits + 1);
   // Wide enough for acc plus a shifted ADC term without overflow.
   localparam int unsigned WideW = numAccBits + numInBits + 1;

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e                              state_q, state_d;
   logic [numRows-1:0][numInBits-1:0]   sreg_q, sreg_d;
   logic [CntW-1:0]                     n_eff_q, n_eff_d;
   logic [CntW-1:0]                     iss_cnt_q, iss_cnt_d;
   logic [CntW-1:0]                     rx_cnt_q, rx_cnt_d;
   logic                                binary_q, binary_d;
   logic                                mac_en_q, mac_en_d;
   logic [numRows-1:0]                  data_p_q, data_p_d;
   logic [numRows-1:0]                  data_n_q, data_n_d;
   logic                                in_ready_q, in_ready_d;
   logic                                acc_valid_q, acc_valid_d;
   logic [numCols-1:0][numAccBits-1:0]  acc_q, acc_d;

   logic                                accept;
   logic                                rx_vld;
   logic                                rx_take;
   logic                                neg_step;
   logic [CntW-1:0]                     n_clamp;
   logic signed [WideW-1:0]             term_w [numCols];
   logic signed [WideW-1:0]             sum_w  [numCols];

`ifdef QR_SEQ_SATURATE_EN
   localparam logic signed [WideW-1:0] AccMax =
      WideW'((64'sd1 <<< (numAccBits - 1)) - 64'sd1);
   localparam logic signed [WideW-1:0] AccMin = -AccMax - WideW'(1);
   logic [numCols-1:0] ovf_q, ovf_d;
`endif

   assign accept = (state_q == StIdle) && bus.in_valid_i && in_ready_q;

   // Effective precision: 0 behaves as 1, anything above numInBits is capped.
   always_comb begin
      if (bus.n_input_bits_cfg == '0) begin
         n_clamp = CntW'(1);
      end else if (32'(bus.n_input_bits_cfg) > numInBits) begin
         n_clamp = CntW'(numInBits);
      end else begin
         n_clamp = CntW'(bus.n_input_bits_cfg);
      end
   end

   // Receive window: mac_en delayed by the wrapper latency marks each returning result.
   if (adcLatency == 0) begin : g_no_lat
      assign rx_vld = mac_en_q;
   end else begin : g_lat
      logic [adcLatency-1:0] vld_pipe_q, vld_pipe_d;

      always_comb begin
         vld_pipe_d    = vld_pipe_q << 1;
         vld_pipe_d[0] = mac_en_q;
      end

      always_ff @(posedge clk) begin
         if (rst) vld_pipe_q <= '0;
         else     vld_pipe_q <= vld_pipe_d;
      end

      assign rx_vld = vld_pipe_q[adcLatency-1];
   end

   assign rx_take  = rx_vld && ((state_q == StRun) || (state_q == StDrain));
   // Bipolar MSB plane carries weight -2^(N-1).
   assign neg_step = !binary_q && (rx_cnt_q == (n_eff_q - CntW'(1)));

   always_comb begin
      for (int c = 0; c < numCols; c++) begin
         term_w[c] = WideW'($signed(adc_out_i[c]));
         term_w[c] = term_w[c] <<< rx_cnt_q;
         if (neg_step) term_w[c] = -term_w[c];
         sum_w[c] = WideW'($signed(acc_q[c])) + term_w[c];
      end
   end

   // Accumulator and receive counter.
   always_comb begin
      acc_d    = acc_q;
      rx_cnt_d = rx_cnt_q;
`ifdef QR_SEQ_SATURATE_EN
      ovf_d    = ovf_q;
`endif
      if (accept) begin
         acc_d    = '0;
         rx_cnt_d = '0;
`ifdef QR_SEQ_SATURATE_EN
         ovf_d    = '0;
`endif
      end else if (rx_take) begin
         rx_cnt_d = rx_cnt_q + CntW'(1);
         for (int c = 0; c < numCols; c++) begin
`ifdef QR_SEQ_SATURATE_EN
            // Once a column has clipped it stays at the clamped value.
            if (!ovf_q[c]) begin
               if (sum_w[c] > AccMax) begin
                  acc_d[c] = AccMax[numAccBits-1:0];
                  ovf_d[c] = 1'b1;
               end else if (sum_w[c] < AccMin) begin
                  acc_d[c] = AccMin[numAccBits-1:0];
                  ovf_d[c] = 1'b1;
               end else begin
                  acc_d[c] = sum_w[c][numAccBits-1:0];
               end
            end
`else
            acc_d[c] = sum_w[c][numAccBits-1:0];
`endif
         end
      end
   end

   // Control FSM and registered bit-plane drive.
   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      n_eff_d     = n_eff_q;
      iss_cnt_d   = iss_cnt_q;
      binary_d    = binary_q;
      mac_en_d    = 1'b0;
      data_p_d    = '0;
      data_n_d    = '0;
      acc_valid_d = acc_valid_q;

      case (state_q)
         StIdle: begin
            if (accept) begin
               n_eff_d   = n_clamp;
               binary_d  = bus.binary_cfg;
               iss_cnt_d = CntW'(1);
               for (int r = 0; r < numRows; r++) begin
                  data_p_d[r] = bus.in_data_i[r][0];
                  sreg_d[r]   = bus.in_data_i[r] >> 1;
               end
               data_n_d = bus.binary_cfg ? '0 : ~data_p_d;
               mac_en_d = 1'b1;
               state_d  = StRun;
            end
         end
         StRun: begin
            if (iss_cnt_q == n_eff_q) begin
               state_d = StDrain;
            end else begin
               for (int r = 0; r < numRows; r++) begin
                  data_p_d[r] = sreg_q[r][0];
                  sreg_d[r]   = sreg_q[r] >> 1;
               end
               data_n_d  = binary_q ? '0 : ~data_p_d;
               mac_en_d  = 1'b1;
               iss_cnt_d = iss_cnt_q + CntW'(1);
            end
         end
         StDrain: begin
            if (rx_cnt_q == n_eff_q) begin
               state_d     = StDone;
               acc_valid_d = 1'b1;
            end
         end
         StDone: begin
            if (bus.acc_ready_i) begin
               state_d     = StIdle;
               acc_valid_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase

      in_ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         sreg_q      <= '0;
         n_eff_q     <= '0;
         iss_cnt_q   <= '0;
         rx_cnt_q    <= '0;
         binary_q    <= 1'b0;
         mac_en_q    <= 1'b0;
         data_p_q    <= '0;
         data_n_q    <= '0;
         in_ready_q  <= 1'b0;
         acc_valid_q <= 1'b0;
         acc_q       <= '0;
`ifdef QR_SEQ_SATURATE_EN
         ovf_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         n_eff_q     <= n_eff_d;
         iss_cnt_q   <= iss_cnt_d;
         rx_cnt_q    <= rx_cnt_d;
         binary_q    <= binary_d;
         mac_en_q    <= mac_en_d;
         data_p_q    <= data_p_d;
         data_n_q    <= data_n_d;
         in_ready_q  <= in_ready_d;
         acc_valid_q <= acc_valid_d;
         acc_q       <= acc_d;
`ifdef QR_SEQ_SATURATE_EN
         ovf_q       <= ovf_d;
`endif
      end
   end

   assign bus.in_ready_o  = in_ready_q;
   assign bus.acc_valid_o = acc_valid_q;
   assign bus.acc_data_o  = acc_q;
   assign mac_en_o        = mac_en_q;
   assign data_p_o        = data_p_q;
   assign data_n_o        = data_n_q;

endmodule

// File: tb/tb_qr_mac_sequencer.sv
module tb_qr_mac_sequencer;
   localparam int NR  = 128;
   localparam int NC  = 8;
   localparam int LAT = 2;
`ifdef QR_SEQ_SATURATE_EN
   localparam logic [7:0] Exp2Sat = 8'd127;
`else
   localparam logic [7:0] Exp2Sat = 8'hF9;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   qr_mac_sequencer_if #(.numAccBits(12)) ifc ();
   qr_mac_sequencer_if #(.numAccBits(8))  ifc2 ();

   logic                  mac_en, mac_en2;
   logic [NR-1:0]         data_p, data_n, data_p2, data_n2;
   logic [NC-1:0][3:0]    adc;

   assign ifc2.n_input_bits_cfg = ifc.n_input_bits_cfg;
   assign ifc2.binary_cfg       = ifc.binary_cfg;
   assign ifc2.in_valid_i       = ifc.in_valid_i;
   assign ifc2.in_data_i        = ifc.in_data_i;
   assign ifc2.acc_ready_i      = ifc.acc_ready_i;

   qr_mac_sequencer #(.numAccBits(12)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (ifc),
      .mac_en_o  (mac_en),
      .data_p_o  (data_p),
      .data_n_o  (data_n),
      .adc_out_i (adc)
   );

   qr_mac_sequencer #(.numAccBits(8)) dut2 (
      .clk       (clk),
      .rst       (rst),
      .bus       (ifc2),
      .mac_en_o  (mac_en2),
      .data_p_o  (data_p2),
      .data_n_o  (data_n2),
      .adc_out_i (adc)
   );

   typedef struct {
      logic              bin;
      logic [7:0]        ncfg;
      logic [7:0]        word;
      logic [7:0][3:0]   adcs;
      logic [11:0]       exp;
      bit                chk2;
      logic [7:0]        exp2;
   } vec_t;

   vec_t vecs[7];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called #1 after a posedge; returns #1 after the posedge of a cycle with in_ready_o=1.
   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (ifc.in_ready_o) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      if (!ok) check("ready_timeout", 128'd0, 128'd1);
   endtask

   function automatic logic [NC-1:0][3:0] adc_for(input vec_t v, input int n_eff, input int c);
      int k = c - 1 - LAT;
      if (k >= 0 && k < n_eff) return {NC{v.adcs[k]}};
      return {NC{4'h6}};
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      bit ok, plane_ok;
      int n_eff, vcyc, men;
      logic bitk;
      string tag;
      n_eff = (v.ncfg == 0) ? 1 : ((v.ncfg > 8) ? 8 : int'(v.ncfg));
      tag   = $sformatf("vec%0d", idx);
      wait_ready(ok);
      if (!ok) return;
      ifc.n_input_bits_cfg = v.ncfg;
      ifc.binary_cfg       = v.bin;
      ifc.in_data_i        = {NR{v.word}};
      ifc.in_valid_i       = 1'b1;
      ifc.acc_ready_i      = 1'b1;
      adc                  = adc_for(v, n_eff, 0);
      vcyc = -1; men = 0; plane_ok = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         // Anything changed after accept must be ignored.
         ifc.in_valid_i       = 1'b0;
         ifc.n_input_bits_cfg = 8'd3;
         ifc.binary_cfg       = ~v.bin;
         ifc.in_data_i        = {NR{~v.word}};
         adc                  = adc_for(v, n_eff, c);
         @(negedge clk);
         if (c == 1) check({tag, "_busy_ready"}, 128'(ifc.in_ready_o), 128'd0);
         if (mac_en) men++;
         if (c <= n_eff) begin
            bitk = v.word[c-1];
            if (data_p !== {NR{bitk}}) plane_ok = 1'b0;
            if (data_n !== (v.bin ? {NR{1'b0}} : {NR{~bitk}})) plane_ok = 1'b0;
         end else if (data_p !== '0 || data_n !== '0) begin
            plane_ok = 1'b0;
         end
         if (ifc.acc_valid_o) begin
            vcyc = c;
            break;
         end
      end
      check({tag, "_valid_cycle"}, 128'(vcyc), 128'(n_eff + LAT + 2));
      check({tag, "_mac_en_cycles"}, 128'(men), 128'(n_eff));
      check({tag, "_bitplanes"}, 128'(plane_ok), 128'd1);
      check({tag, "_acc"}, 128'(ifc.acc_data_o), 128'({NC{v.exp}}));
      if (v.chk2) check({tag, "_acc8"}, 128'(ifc2.acc_data_o), 128'({NC{v.exp2}}));
      @(posedge clk); #1;
      check({tag, "_post_valid"}, 128'(ifc.acc_valid_o), 128'd0);
      check({tag, "_post_ready"}, 128'(ifc.in_ready_o), 128'd1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      bit ok, stable, busy_bad, seen;
      logic [NC-1:0][11:0] held;

      vecs[0] = '{1'b0, 8'd4,  8'h05, 32'h0000_4321, 12'hFF1, 1'b0, 8'h00};
      vecs[1] = '{1'b1, 8'd8,  8'hA5, 32'h7777_7777, 12'h6F9, 1'b1, Exp2Sat};
      vecs[2] = '{1'b1, 8'd0,  8'h01, 32'h0000_000D, 12'hFFD, 1'b0, 8'h00};
      vecs[3] = '{1'b0, 8'd1,  8'h01, 32'h0000_0005, 12'hFFB, 1'b0, 8'h00};
      vecs[4] = '{1'b0, 8'd20, 8'h80, 32'h8888_8888, 12'h008, 1'b0, 8'h00};
      vecs[5] = '{1'b1, 8'd3,  8'hFF, 32'h0000_02F1, 12'h007, 1'b0, 8'h00};
      vecs[6] = '{1'b0, 8'd2,  8'h02, 32'h0000_0078, 12'hFEA, 1'b0, 8'h00};

      ifc.n_input_bits_cfg = '0;
      ifc.binary_cfg       = 1'b0;
      ifc.in_valid_i       = 1'b0;
      ifc.in_data_i        = '0;
      ifc.acc_ready_i      = 1'b1;
      adc                  = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready",  128'(ifc.in_ready_o),  128'd0);
      check("rst_mac_en",    128'(mac_en),          128'd0);
      check("rst_data_p",    128'(data_p),          128'd0);
      check("rst_data_n",    128'(data_n),          128'd0);
      check("rst_acc_valid", 128'(ifc.acc_valid_o), 128'd0);
      check("rst_acc_data",  128'(ifc.acc_data_o),  128'd0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_release_ready", 128'(ifc.in_ready_o), 128'd1);

      for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

      // Reset mid-RUN (bipolar N=8): in-flight work is discarded.
      wait_ready(ok);
      ifc.n_input_bits_cfg = 8'd8;
      ifc.binary_cfg       = 1'b0;
      ifc.in_data_i        = {NR{8'h5A}};
      ifc.in_valid_i       = 1'b1;
      adc                  = {NC{4'h3}};
      repeat (3) begin
         @(posedge clk); #1;
         ifc.in_valid_i = 1'b0;
      end
      check("midrun_mac_en", 128'(mac_en), 128'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_mac_en",    128'(mac_en),          128'd0);
      check("midrst_acc_valid", 128'(ifc.acc_valid_o), 128'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("midrst_in_ready", 128'(ifc.in_ready_o), 128'd1);
      seen = 1'b0;
      repeat (30) begin
         @(posedge clk); #1;
         if (ifc.acc_valid_o || mac_en) seen = 1'b1;
      end
      check("midrst_no_result", 128'(seen), 128'd0);

      // Backpressure: result held while acc_ready_i is low, next request waits.
      wait_ready(ok);
      ifc.n_input_bits_cfg = 8'd2;
      ifc.binary_cfg       = 1'b1;
      ifc.in_data_i        = {NR{8'h03}};
      ifc.in_valid_i       = 1'b1;
      ifc.acc_ready_i      = 1'b0;
      adc                  = {NC{4'h1}};
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         ifc.in_valid_i = 1'b0;
         if (ifc.acc_valid_o) begin
            seen = 1'b1;
            break;
         end
      end
      check("bp_valid_seen", 128'(seen), 128'd1);
      check("bp_acc", 128'(ifc.acc_data_o), 128'({NC{12'd3}}));
      held                 = ifc.acc_data_o;
      ifc.in_valid_i       = 1'b1;
      ifc.n_input_bits_cfg = 8'd1;
      ifc.in_data_i        = {NR{8'h01}};
      adc                  = {NC{4'h2}};
      stable = 1'b1; busy_bad = 1'b0;
      repeat (10) begin
         @(posedge clk); #1;
         if (ifc.acc_data_o !== held || !ifc.acc_valid_o) stable = 1'b0;
         if (ifc.in_ready_o || mac_en) busy_bad = 1'b1;
      end
      check("bp_stable", 128'(stable), 128'd1);
      check("bp_not_accepted", 128'(busy_bad), 128'd0);
      ifc.acc_ready_i = 1'b1;
      @(posedge clk); #1;
      check("bp_hs_valid", 128'(ifc.acc_valid_o), 128'd0);
      check("bp_hs_ready", 128'(ifc.in_ready_o),  128'd1);
      check("bp_hs_mac_en", 128'(mac_en), 128'd0);
      @(posedge clk); #1;
      ifc.in_valid_i = 1'b0;
      check("bp_next_mac_en", 128'(mac_en), 128'd1);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (ifc.acc_valid_o) begin
            seen = 1'b1;
            break;
         end
      end
      check("bp_next_valid", 128'(seen), 128'd1);
      check("bp_next_acc", 128'(ifc.acc_data_o), 128'({NC{12'd2}}));
      @(posedge clk); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/qr_mac_sequencer.md
# qr_mac_sequencer

Bit-serial MAC sequencer that drives the digital MAC port of the QR accelerator wrapper. It accepts one multi-bit input vector per request and presents it to the array one bit-plane per cycle (LSB first) as `data_p`/`data_n` row drives. It collects the per-column encoded ADC partial sums returning from the wrapper and shift-adds them into a full-precision per-column dot product. It sits between the layer/tile controller and the analog wrapper.

## Interface
Parameters:
- `numRows`, 128: array rows (input vector length).
- `numCols`, 8: array columns (output channels).
- `numAdcBits`, 4: signed ADC partial-sum width.
- `numInBits`, 8: maximum input precision.
- `numAccBits`, 12: signed accumulator width per column.
- `numCfgBits`, 8: config field width.
- `adcLatency`, 2: cycles from a bit-plane on `data_p_o`/`data_n_o` to its result on `adc_out_i`.

Ports (one clock `clk`; reset `rst` is synchronous and active-high):
- `clk` in 1: clock.
- `rst` in 1: synchronous active-high reset.
- `n_input_bits_cfg` in numCfgBits: input precision N.
- `binary_cfg` in 1: 1 = unsigned binary inputs; 0 = signed bipolar inputs.
- `in_valid_i` in 1: input vector valid.
- `in_ready_o` out 1: sequencer can accept a vector.
- `in_data_i` in numRows×numInBits: per-row input word (two's complement when `binary_cfg`=0).
- `mac_en_o` out 1: drives wrapper `mac_en_i`.
- `data_p_o` out numRows: drives wrapper `data_p_i`.
- `data_n_o` out numRows: drives wrapper `data_n_i`.
- `adc_out_i` in numCols×numAdcBits: signed encoded ADC output from the wrapper.
- `acc_valid_o` out 1: result valid.
- `acc_ready_i` in 1: result consumer ready.
- `acc_data_o` out numCols×numAccBits: signed per-column result.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `in_ready_o`=1.
  - On `in_valid_i && in_ready_o`, capture `in_data_i` into a row shift register, latch effective N and `binary_cfg`, clear the accumulators, and go to RUN.
- Effective N = clamp(`n_input_bits_cfg`, 1, numInBits). A value of 0 is treated as 1.
- RUN:
  - `mac_en_o`=1. Issue bit k (k=0..N-1) of every row, one bit per cycle.
  - Binary mode: `data_p_o`=bit, `data_n_o`=0. Rows with bit 0 sit at reset drive.
  - Bipolar mode: `data_p_o`=bit, `data_n_o`=~bit.
  - After issuing bit N-1, go to DRAIN.
- DRAIN:
  - `mac_en_o`=0, `data_p_o`=`data_n_o`=0.
  - Wait until all N results have been received, then go to DONE.
- Receive path:
  - A receive counter tracks the issue pipeline with delay `adcLatency`.
  - Result k updates each column as acc += sext(adc)<<k.
  - In bipolar mode, result N-1 is subtracted instead (MSB weight −2^(N-1)).
  - All arithmetic is signed, sign-extended to numAccBits.
- DONE:
  - `acc_valid_o`=1 and `acc_data_o` holds stable until `acc_valid_o && acc_ready_i`, then go to IDLE.
- Config inputs are sampled only at the accept handshake. Changes mid-operation have no effect.
- `adc_out_i` is ignored outside the expected result window.

## Timing
- Reset values: `in_ready_o`=0 during reset and 1 the cycle after; `mac_en_o`=0; `data_p_o`=0; `data_n_o`=0; `acc_valid_o`=0; `acc_data_o`=0; state IDLE.
- All outputs are registered.
- Accept at cycle 0: bit k is on `data_*_o` in cycle 1+k. `mac_en_o` is high for cycles 1..N.
- Result k is sampled from `adc_out_i` in cycle 1+k+`adcLatency`.
- `acc_valid_o` rises in cycle N+`adcLatency`+2.
- Handshake in cycle t: `acc_valid_o`=0 and `in_ready_o`=1 in cycle t+1. No overlap between requests.
- With `acc_ready_i` held high, request-to-request period is N+`adcLatency`+3 cycles.
- `rst` mid-operation: returns to IDLE next cycle, drops `mac_en_o`, discards in-flight results. Late `adc_out_i` values are ignored.

## Configuration
- `QR_SEQ_SATURATE_EN` defined: each accumulate step saturates to [−2^(numAccBits−1), 2^(numAccBits−1)−1]. A sticky per-request overflow flag forces the clamped value.
- Not defined: accumulation wraps modulo 2^numAccBits.

## Test plan
- Reset: assert `rst` 3 cycles mid-RUN (N=8) → next cycle `mac_en_o`=0, `acc_valid_o`=0. No result ever appears. `in_ready_o`=1 after `rst` drops.
- Bipolar, N=4, all rows=4'b0101 → cycles 1..4 `data_p_o` = all-1, 0, all-1, 0 and `data_n_o` is its complement. ADC model returns 1,2,3,4 → `acc_data_o` = 1+4+12−32 = −15 in all columns, valid at cycle 8.
- Binary, N=8, ADC model returns 7 every step → `acc_data_o` = 7×255 = 1785, valid at cycle 12. `data_n_o`=0 throughout.
- `n_input_bits_cfg`=0 → exactly one `mac_en_o` cycle; result equals sext of the single ADC value.
- Backpressure: `acc_ready_i`=0 for 10 cycles → `acc_data_o` stable, `in_ready_o`=0, and a new `in_valid_i` is not accepted until one cycle after the handshake.
- numAccBits=8, binary, N=8, ADC=7 → with `QR_SEQ_SATURATE_EN`: 127. Without: 1785 mod 256 = −7 (0xF9).
